// File: rtl/mem_access_initiator_if.sv
// MOV/MOC memory bus between the access initiator (master)
// and the big-endian RAM (slave).
interface mem_access_initiator_if #(
   parameter int ADDR_W = 9
);
   logic              MOV;
   logic              MemRead;
   logic              MemWrite;
   logic [ADDR_W-1:0] Address;
   logic [31:0]       DataToMem;
   logic [31:0]       DataFromMem;
   logic              MOC;

   modport master (
      output MOV, MemRead, MemWrite, Address, DataToMem,
      input  DataFromMem, MOC
   );

   modport slave (
      input  MOV, MemRead, MemWrite, Address, DataToMem,
      output DataFromMem, MOC
   );
endinterface

// File: rtl/mem_access_initiator.sv
// Four-phase MOV/MOC bus master: word fetch + lane extract for loads,
// read-modify-write for sub-word stores. MEM_TIMEOUT_EN adds a phase timeout.
module mem_access_initiator #(
   parameter int ADDR_W = 9
`ifdef MEM_TIMEOUT_EN
   , parameter int TIMEOUT = 15
`endif
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   req,
   input  logic                   rw,
   input  logic [1:0]             size,
   input  logic                   sgn,
   input  logic [ADDR_W-1:0]      addr,
   input  logic [31:0]            wdata,
   output logic                   busy,
   output logic                   done,
   output logic                   err,
   output logic [31:0]            rdata,
   mem_access_initiator_if.master bus
);
   typedef enum logic [2:0] {
      IDLE, SETUP, ASSERT, RELEASE, DONE
   } state_t;

   state_t      state;
   logic        l_rw, l_sgn, wr_phase;
   logic [1:0]  l_size, l_off;
   logic [15:0] l_wdata;
   logic [31:0] buffer, merged, ext;
   logic [7:0]  lane_b;
   logic [15:0] lane_h;
   logic        bad, word_st, rmw, expired;

   always_comb begin
      bad = (size == 2'b11)
         || (size == 2'b01 && addr[0])
         || (size == 2'b10 && addr[1:0] != 2'b00);
      word_st = rw && size == 2'b10;
      rmw = l_rw && l_size != 2'b10;
   end

   // Big-endian lanes: offset 0 lives in bits 31:24.
   always_comb begin
      merged = buffer;
      unique case (l_off)
         2'd0:    lane_b = buffer[31:24];
         2'd1:    lane_b = buffer[23:16];
         2'd2:    lane_b = buffer[15:8];
         default: lane_b = buffer[7:0];
      endcase
      lane_h = l_off[1] ? buffer[15:0] : buffer[31:16];
      if (l_size == 2'b00) begin
         unique case (l_off)
            2'd0:    merged[31:24] = l_wdata[7:0];
            2'd1:    merged[23:16] = l_wdata[7:0];
            2'd2:    merged[15:8]  = l_wdata[7:0];
            default: merged[7:0]   = l_wdata[7:0];
         endcase
      end else if (l_size == 2'b01) begin
         if (l_off[1]) merged[15:0] = l_wdata;
         else          merged[31:16] = l_wdata;
      end
      unique case (l_size)
         2'b00:   ext = {{24{l_sgn & lane_b[7]}}, lane_b};
         2'b01:   ext = {{16{l_sgn & lane_h[15]}}, lane_h};
         default: ext = buffer;
      endcase
   end

`ifdef MEM_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
   logic [CW-1:0] cnt;

   // Restarts on entry to ASSERT (from SETUP) and to RELEASE (on MOC).
   always_ff @(posedge clock) begin
      if (!reset || !(state == ASSERT || state == RELEASE)
          || (state == ASSERT && bus.MOC))
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end
   assign expired = (cnt == LAST);
`else
   assign expired = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (!reset) begin
         state         <= IDLE;
         busy          <= 1'b0;
         done          <= 1'b0;
         err           <= 1'b0;
         rdata         <= '0;
         bus.MOV       <= 1'b0;
         bus.MemRead   <= 1'b0;
         bus.MemWrite  <= 1'b0;
         bus.Address   <= '0;
         bus.DataToMem <= '0;
         l_rw          <= 1'b0;
         l_sgn         <= 1'b0;
         l_size        <= '0;
         l_off         <= '0;
         l_wdata       <= '0;
         wr_phase      <= 1'b0;
         buffer        <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: if (req) begin
               l_rw    <= rw;
               l_sgn   <= sgn;
               l_size  <= size;
               l_off   <= addr[1:0];
               l_wdata <= wdata[15:0];
               busy    <= 1'b1;
               if (bad) begin
                  err   <= 1'b1;
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  bus.Address   <= {addr[ADDR_W-1:2], 2'b00};
                  bus.DataToMem <= wdata;
                  bus.MemRead   <= !word_st;
                  bus.MemWrite  <= word_st;
                  wr_phase      <= word_st;
                  state         <= SETUP;
               end
            end
            SETUP: begin
               bus.MOV <= 1'b1;
               state   <= ASSERT;
            end
            ASSERT: if (bus.MOC) begin
               buffer       <= bus.DataFromMem;
               bus.MOV      <= 1'b0;
               bus.MemRead  <= 1'b0;
               bus.MemWrite <= 1'b0;
               state        <= RELEASE;
            end else if (expired) begin
               bus.MOV      <= 1'b0;
               bus.MemRead  <= 1'b0;
               bus.MemWrite <= 1'b0;
               rdata        <= '0;
               err          <= 1'b1;
               done         <= 1'b1;
               state        <= DONE;
            end
            RELEASE: if (!bus.MOC) begin
               if (rmw && !wr_phase) begin
                  buffer        <= merged;
                  bus.DataToMem <= merged;
                  bus.MemWrite  <= 1'b1;
                  wr_phase      <= 1'b1;
                  state         <= SETUP;
               end else begin
                  if (!l_rw) rdata <= ext;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end else if (expired) begin
               rdata <= '0;
               err   <= 1'b1;
               done  <= 1'b1;
               state <= DONE;
            end
            DONE: begin
               busy  <= 1'b0;
               err   <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_access_initiator.sv
// Directed bench for mem_access_initiator: word RAM responder with
// selectable MOC behaviour and a byte-level reference model.
module tb_mem_access_initiator;
   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic        reset, req, rw, sgn;
   logic [1:0]  size;
   logic [8:0]  addr;
   logic [31:0] wdata;
   logic        busy, done, err;
   logic [31:0] rdata;

   mem_access_initiator_if #(.ADDR_W(9)) bus ();

   mem_access_initiator #(.ADDR_W(9)) dut (
      .clock(clock), .reset(reset), .req(req), .rw(rw),
      .size(size), .sgn(sgn), .addr(addr), .wdata(wdata),
      .busy(busy), .done(done), .err(err), .rdata(rdata),
      .bus(bus)
   );

   // Responder: mode 0 = zero-wait, 1 = one extra cycle per edge, 2 = MOC stuck low
   logic [31:0] mem [0:127];
   int          mode = 0;
   logic        moc_q = 1'b0;
   logic        mov_d = 1'b0;
   logic        ld_en = 1'b0;
   logic [6:0]  ld_idx = '0;
   logic [31:0] ld_word = '0;
   int          n_rd = 0, n_wr = 0, n_mov = 0;

   assign bus.MOC = (mode == 0) ? bus.MOV : (mode == 1) ? moc_q : 1'b0;
   assign bus.DataFromMem = mem[bus.Address[8:2]];

   always @(posedge clock) begin
      moc_q <= bus.MOV;
      mov_d <= bus.MOV;
      if (ld_en) mem[ld_idx] <= ld_word;
      else if (bus.MOV && bus.MemWrite) mem[bus.Address[8:2]] <= bus.DataToMem;
      if (bus.MOV) n_mov <= n_mov + 1;
      if (bus.MOV && !mov_d) begin
         if (bus.MemWrite) n_wr <= n_wr + 1;
         else              n_rd <= n_rd + 1;
      end
   end

   logic [31:0] ref_mem [0:127];
   logic [31:0] exp_rdata = '0;
   logic [8:0]  exp_addr = '0;
   logic [8:0]  prev_addr = '0;
   int          checks = 0, errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, required %h", nm, act, exp);
      end
   endtask

   // One cycle; bus phase checked every cycle MOV is high.
   task automatic step();
      @(posedge clock);
      #1;
      if (bus.MOV) begin
         chk("bus_addr", 32'(bus.Address), 32'(exp_addr));
         chk("addr_stable", 32'(bus.Address), 32'(prev_addr));
         chk("strobe_onehot", 32'(bus.MemRead ^ bus.MemWrite), 32'd1);
      end
      prev_addr = bus.Address;
   endtask

   task automatic load(input logic [8:0] a, input logic [31:0] w);
      @(negedge clock);
      ld_en = 1'b1;
      ld_idx = a[8:2];
      ld_word = w;
      @(posedge clock);
      #1 ld_en = 1'b0;
      ref_mem[a[8:2]] = w;
   endtask

   task automatic model(input bit r, input logic [1:0] s, input bit g,
                        input logic [8:0] a, input logic [31:0] w,
                        output bit e, output int lat, output int nr,
                        output int nw, output logic [31:0] rd);
      int n, o;
      logic [7:0]  b [4];
      logic [31:0] word, v;
      o = int'(a[1:0]);
      n = (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
      e = (s == 2'b11) || (o % n != 0);
      rd = exp_rdata;
      nr = 0;
      nw = 0;
      lat = 1;
      if (!e) begin
         word = ref_mem[a[8:2]];
         for (int i = 0; i < 4; i++) b[i] = word[31-8*i -: 8];
         if (r) begin
            for (int k = 0; k < n; k++) b[o+k] = w[8*(n-1-k) +: 8];
            ref_mem[a[8:2]] = {b[0], b[1], b[2], b[3]};
            nw = 1;
            nr = (n < 4) ? 1 : 0;
         end else begin
            v = '0;
            for (int k = 0; k < n; k++) v = (v << 8) | 32'(b[o+k]);
            if (g && n < 4 && v[8*n-1]) v = v - (32'd1 << (8*n));
            rd = v;
            exp_rdata = v;
            nr = 1;
         end
         lat = (nr + nw == 2) ? 7 : 4;
         if (mode == 1) lat = lat + 2 * (nr + nw);
      end
   endtask

   task automatic op(input string nm, input bit r, input logic [1:0] s,
                     input bit g, input logic [8:0] a, input logic [31:0] w,
                     input bit pin, input logic [31:0] pin_val);
      bit e, busy_ok;
      int lat, nr, nw, cyc, r0, w0, m0;
      logic [31:0] rd;
      model(r, s, g, a, w, e, lat, nr, nw, rd);
      r0 = n_rd;
      w0 = n_wr;
      m0 = n_mov;
      @(negedge clock);
      req = 1'b1; rw = r; size = s; sgn = g; addr = a; wdata = w;
      exp_addr = {a[8:2], 2'b00};
      step();
      req = 1'b0;
      cyc = 1;
      busy_ok = 1'b1;
      while (!done && cyc < 200) begin
         if (!busy) busy_ok = 1'b0;
         step();
         cyc++;
      end
      chk({nm, "_latency"}, 32'(cyc), 32'(lat));
      chk({nm, "_err"}, 32'(err), 32'(e));
      chk({nm, "_rdata"}, rdata, rd);
      if (pin) chk({nm, "_rdata_lit"}, rdata, pin_val);
      chk({nm, "_busy"}, 32'(busy_ok), 32'd1);
      chk({nm, "_reads"}, 32'(n_rd - r0), 32'(nr));
      chk({nm, "_writes"}, 32'(n_wr - w0), 32'(nw));
      chk({nm, "_mov_cycles"}, 32'(n_mov - m0),
          32'((nr + nw) * ((mode == 1) ? 2 : 1)));
      if (r && !e) chk({nm, "_mem"}, mem[a[8:2]], ref_mem[a[8:2]]);
      step();
      chk({nm, "_pulse_end"}, 32'({done, busy}), 32'd0);
   endtask

   task automatic start_stuck_load(input logic [8:0] a);
      mode = 2;
      @(negedge clock);
      req = 1'b1; rw = 1'b0; size = 2'b10; sgn = 1'b0; addr = a; wdata = '0;
      exp_addr = a;
      step();
      req = 1'b0;
   endtask

   task automatic check_reset(input string nm);
      chk({nm, "_ctrl"}, 32'({bus.MOV, bus.MemRead, bus.MemWrite, done, err, busy}), 32'd0);
      chk({nm, "_addr"}, 32'(bus.Address), 32'd0);
      chk({nm, "_wdata"}, bus.DataToMem, 32'd0);
      chk({nm, "_rdata"}, rdata, 32'd0);
   endtask

   initial begin
      int cyc, m0;
      bit hang;
      reset = 1'b0; req = 1'b0; rw = 1'b0; size = '0;
      sgn = 1'b0; addr = '0; wdata = '0;
      step();
      step();
      check_reset("reset");
      @(negedge clock) reset = 1'b1;

      load(9'h010, 32'hDEADBEEF);
      load(9'h020, 32'h11223344);
      load(9'h024, 32'h00000000);

      op("word_load", 0, 2'b10, 0, 9'h010, 0, 1, 32'hDEADBEEF);
      load(9'h010, 32'hDEAD8001);
      op("half_s", 0, 2'b01, 1, 9'h012, 0, 1, 32'hFFFF8001);
      op("half_u", 0, 2'b01, 0, 9'h012, 0, 1, 32'h00008001);
      op("byte_rmw", 1, 2'b00, 0, 9'h021, 32'h000000AA, 0, 0);
      chk("byte_rmw_word", mem[8], 32'h11AA3344);
      op("misaligned", 0, 2'b10, 0, 9'h006, 0, 0, 0);
      op("byte_s1", 0, 2'b00, 1, 9'h021, 0, 1, 32'hFFFFFFAA);
      op("byte_u3", 0, 2'b00, 0, 9'h023, 0, 1, 32'h00000044);
      op("byte_s0", 0, 2'b00, 1, 9'h020, 0, 1, 32'h00000011);
      op("bad_size", 0, 2'b11, 0, 9'h000, 0, 0, 0);
      op("half_odd", 1, 2'b01, 0, 9'h011, 32'h1234, 0, 0);

      mode = 1;
      op("half_rmw_slow", 1, 2'b01, 0, 9'h022, 32'h0000BEEF, 0, 0);
      chk("half_rmw_word", mem[8], 32'h11AABEEF);
      op("word_st_slow", 1, 2'b10, 0, 9'h024, 32'hCAFEF00D, 0, 0);
      op("word_ld_slow", 0, 2'b10, 0, 9'h024, 0, 1, 32'hCAFEF00D);
      op("byte_ld_slow", 0, 2'b00, 1, 9'h026, 0, 1, 32'hFFFFFFF0);
      mode = 0;

`ifdef MEM_TIMEOUT_EN
      m0 = n_mov;
      start_stuck_load(9'h010);
      cyc = 1;
      while (!done && cyc < 200) begin
         step();
         cyc++;
      end
      chk("timeout_latency", 32'(cyc), 32'd17);
      chk("timeout_err", 32'(err), 32'd1);
      chk("timeout_rdata", rdata, 32'd0);
      chk("timeout_mov_cycles", 32'(n_mov - m0), 32'd15);
      exp_rdata = '0;
      step();
      start_stuck_load(9'h010);
`else
      start_stuck_load(9'h010);
      hang = 1'b0;
      for (int i = 0; i < 100; i++) begin
         step();
         if (done || !busy) hang = 1'b1;
      end
      chk("no_timeout_wait", 32'(hang), 32'd0);
`endif

      cyc = 0;
      while (!bus.MOV && cyc < 10) begin
         step();
         cyc++;
      end
      chk("mid_mov_high", 32'(bus.MOV), 32'd1);
      @(negedge clock) reset = 1'b0;
      step();
      chk("mid_reset", 32'({bus.MOV, busy, done}), 32'd0);
      check_reset("mid_reset_regs");
      @(negedge clock) reset = 1'b1;
      mode = 0;
      exp_rdata = '0;
      op("after_reset", 0, 2'b10, 0, 9'h010, 0, 1, 32'hDEAD8001);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mem_access_initiator.md
# mem_access_initiator

Bus-master side of the MOV/MOC memory handshake. Accepts one load/store request at a time from the control unit and runs the four-phase MOV/MOC exchange against the 512-byte big-endian RAM. Byte and halfword loads are handled by aligned-word fetch plus lane extraction; byte and halfword stores by read-modify-write. The block sits between the control unit / MAR / MDR and the RAM, so the control unit no longer sequences MOV or waits on MOC itself.

## Interface
- ADDR_W, 9, byte address width
- TIMEOUT, 15, max cycles waited in any handshake phase (used only with MEM_TIMEOUT_EN)
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- req  in  1  request strobe; sampled only in IDLE
- rw  in  1  1 = store, 0 = load
- size  in  2  00 byte, 01 halfword, 10 word; 11 reserved, flagged as err
- sgn  in  1  loads only: 1 = sign-extend, 0 = zero-extend
- addr  in  ADDR_W  byte address
- wdata  in  32  store data, right-justified
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done: misaligned access, bad size, or timeout
- rdata  out  32  load result, valid with done, held until next done
- MOV  out  1  memory operation valid
- MemRead  out  1  read strobe, stable while MOV = 1
- MemWrite  out  1  write strobe, stable while MOV = 1
- Address  out  ADDR_W  word-aligned address {addr[ADDR_W-1:2], 2'b00}
- DataToMem  out  32  write word
- DataFromMem  in  32  read word, big-endian (byte at offset 0 in bits 31:24)
- MOC  in  1  memory operation complete

## Operation
- States: IDLE, SETUP, ASSERT, RELEASE, DONE.
- IDLE: on req = 1, latch rw, size, sgn, addr and wdata. Misaligned (half with addr[0] = 1, word with addr[1:0] != 0) or size = 11 goes straight to DONE with err = 1 and no bus cycle. Otherwise go to SETUP. The phase is read for loads and sub-word stores, and write for word stores.
- SETUP: drive Address, DataToMem and MemRead/MemWrite for the phase; MOV = 0.
- ASSERT: MOV = 1. When MOC = 1 is sampled, capture DataFromMem into the internal word buffer and go to RELEASE.
- RELEASE: MOV = 0 and strobes low. Wait for MOC = 0.
  - Sub-word store in the read phase: merge into the buffer, switch to the write phase, return to SETUP.
  - Otherwise go to DONE.
- Merge, with o = addr[1:0]:
  - Byte store writes wdata[7:0] to buffer bits [31-8o -: 8].
  - Half store writes wdata[15:0] to [31:16] when o = 0, or to [15:0] when o = 2.
  - All other bytes are preserved.
- Extract:
  - Byte load takes lane [31-8o -: 8]; half load takes [31:16] or [15:0]; word load takes all 32 bits.
  - Extension is per sgn.
  - For stores, rdata is unchanged.
- DONE: done = 1 for one cycle, then IDLE. A req seen while busy or during DONE is ignored, not queued.
- Reset (reset = 0 at an edge): state goes to IDLE. MOV, MemRead, MemWrite, done, err, busy, Address, DataToMem and rdata all become 0. Any in-flight access is abandoned and MOV drops on that edge.

## Timing
- Acceptance edge = the edge where IDLE samples req = 1.
- Zero-wait responder (MOC rises in the first ASSERT cycle and falls in the first RELEASE cycle):
  - Word access or sub-word load: done in the 4th cycle after acceptance.
  - Sub-word store (RMW): done in the 7th cycle after acceptance.
  - Misaligned access: done in the 1st cycle after acceptance.
- Each extra cycle the responder holds MOC low in ASSERT, or high in RELEASE, adds one cycle.
- Address, DataToMem and the strobes are stable from SETUP through the end of ASSERT. MOV never rises in the same cycle that the address changes.

## Configuration
- MEM_TIMEOUT_EN defined:
  - A counter is cleared on entry to ASSERT and to RELEASE and increments every cycle in those states.
  - When it reaches TIMEOUT, MOV and the strobes drop, rdata is set to 0, and the block enters DONE with err = 1.
  - A RMW aborts without performing its write phase.
- MEM_TIMEOUT_EN undefined: no counter; the block waits on MOC indefinitely, and err comes only from misalignment or bad size.

## Test plan
- Word load: addr 0x010, memory bytes 10..13 = DE AD BE EF. Required: done in cycle 4 with rdata = 0xDEADBEEF and err = 0, and MOV high for exactly 1 cycle.
- Signed half load: addr 0x012, bytes = 80 01. With sgn = 1, rdata = 0xFFFF8001; with sgn = 0, rdata = 0x00008001.
- Byte store RMW: word at 0x020 = 0x11223344, store byte 0xAA at 0x021. Required: one read then one write; the word becomes 0x11AA3344; done in cycle 7.
- Misaligned word load at 0x006: required done + err in cycle 1, with MOV never asserted.
- Timeout (MEM_TIMEOUT_EN defined, TIMEOUT = 15): with MOC stuck at 0, MOV drops after 15 ASSERT cycles, then done with err = 1 and rdata = 0. With the macro undefined, busy stays high and done never pulses within 100 cycles.
- Reset mid-access: drive reset = 0 during ASSERT. Required: at the next edge MOV = 0, busy = 0 and state = IDLE; a fresh word load afterwards completes normally.
